sync_fifo_ext: RTL and testbench
================================

// Module: sync_fifo_ext
// PURPOSE
//  Single-clock FIFO, successor to the basic sync FIFO: arbitrary (non-power-of-2) depth, selectable
//  standard/first-word-fall-through read mode, programmable almost-full/almost-empty thresholds,
//  occupancy output and sticky overflow/underflow error flags. Sits between producer/consumer
//  datapath stages in the same clock domain; drop-in where the basic FIFO lacks flow-control margin.
// PARAMETERS
//  DATA_WIDTH  8           data word width, >=1
//  DEPTH       16          number of entries, >=2, any integer (not restricted to power of 2)
//  FWFT        0           0 = standard read (registered dout, 1-cycle latency); 1 = first-word-fall-through
//  AF_THRESH   DEPTH-2     almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   2           almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1                      clock, all state on rising edge
//  rst           in   1                      reset, asynchronous, active-high
//  wr_en         in   1                      write request
//  din           in   DATA_WIDTH             write data
//  rd_en         in   1                      read request (FWFT: acknowledge of head word)
//  dout          out  DATA_WIDTH             read data
//  valid         out  1                      dout holds a valid word (see BEHAVIOUR)
//  full          out  1                      count == DEPTH
//  empty         out  1                      count == 0
//  almost_full   out  1                      count >= AF_THRESH
//  almost_empty  out  1                      count <= AE_THRESH
//  count         out  $clog2(DEPTH+1)        current occupancy, 0..DEPTH
//  overflow      out  1                      sticky: write rejected
//  underflow     out  1                      sticky: read of empty FIFO
//  clr_err       in   1                      synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0, dout=0, valid=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, overflow=underflow=0. Memory contents not reset. Reset mid-operation discards all data.
//  - rd_acc = rd_en & !empty; wr_acc = wr_en & (!full | rd_acc). Write while full is accepted only
//    when a read is accepted in the same cycle. Read while empty is never accepted (no write bypass).
//  - Pointers advance by 1 on acceptance and wrap DEPTH-1 -> 0 explicitly (no power-of-2 masking).
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither. Registered.
//  - full/empty/almost_* are combinational decodes of registered count; all update the cycle after
//    the accepting edge. Write into empty FIFO: empty deasserts the next cycle.
//  - FWFT=0: on rd_acc, dout <= mem[rd_ptr] at that edge; valid high exactly the following cycle
//    (1-cycle pulse per read); dout holds its last value otherwise.
//  - FWFT=1: dout = mem[rd_ptr] whenever !empty; valid = !empty; rd_en pops the head and the next
//    word (if any) appears the cycle after. dout value is don't-care while empty.
//  - overflow set on cycle where wr_en & !wr_acc; underflow set where rd_en & empty. Both sticky until
//    clr_err or rst. Set event and clr_err in same cycle: flag stays/becomes 1 (set wins).
//  - Rejected writes/reads change no pointer, memory or count.
// TESTING
//  1 Reset: assert rst mid-burst with count=5 -> next cycle count=0, empty=1, valid=0, dout=0, flags 0.
//  2 Fill DEPTH=16 with 0x00..0x0F, then 17th write -> full=1, count=16, overflow=1, entry 0 unchanged;
//    drain FWFT=0 -> dout 0x00..0x0F each one cycle after rd_en with valid pulse; then empty=1.
//  3 Full + wr_en&rd_en same cycle (din=0xAA) -> both accepted, count stays 16, 0xAA read last.
//  4 Empty + wr_en&rd_en same cycle -> write only, count=1, underflow=1; clr_err next cycle -> underflow=0.
//  5 DEPTH=5, FWFT=1: stream 20 words with random rd_en/wr_en -> order preserved across pointer wrap,
//    dout equals head whenever valid, count matches scoreboard every cycle.
//  6 AF_THRESH=14, AE_THRESH=2: count 2->3 drops almost_empty; 13->14 raises almost_full, next cycle.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO that accepts any depth. It has a standard or first-word-fall-through
// read mode, programmable almost-full and almost-empty thresholds, an occupancy output,
// and sticky overflow/underflow error flags.
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [CW-1:0]         count_nxt_s;

    // Status decodes of the registered occupancy.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {CW{1'b0}});
    end

    // Acceptance: a read needs data; a write needs room, or a simultaneous accepted read.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        if (rd_en && !empty_s) begin
            rd_acc_s = 1'b1;
        end else begin
            rd_acc_s = 1'b0;
        end
        if (wr_en && (!full_s || rd_acc_s)) begin
            wr_acc_s = 1'b1;
        end else begin
            wr_acc_s = 1'b0;
        end
    end

    // Next occupancy: a write and a read in the same cycle cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array. It is not reset, because the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy. The wrap at DEPTH-1 is explicit so that odd depths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky error flags. A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && !wr_acc_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head-of-queue word is presented directly whenever the FIFO holds data.
            always_comb begin
                dout  = mem_r[rd_ptr_r];
                valid = !empty_s;
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_r;
            logic                  valid_r;

            // Registered read port: a 1-cycle valid pulse per accepted read, and dout holds between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_r  <= {DATA_WIDTH{1'b0}};
                    valid_r <= 1'b0;
                end else begin
                    if (rd_acc_s) begin
                        dout_r <= mem_r[rd_ptr_r];
                    end
                    valid_r <= rd_acc_s;
                end
            end

            // Drive the read port from its registers.
            always_comb begin
                dout  = dout_r;
                valid = valid_r;
            end
        end
    endgenerate

    // Output mapping.
    always_comb begin
        full         = full_s;
        empty        = empty_s;
        almost_full  = (count_r >= AF_C);
        almost_empty = (count_r <= AE_C);
        count        = count_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Randomised self-checking bench for sync_fifo_ext. It uses two instances: depth 16 with
// standard reads, and depth 5 with first-word-fall-through. A queue-based reference model
// checks each instance every cycle.
module tb_sync_fifo_ext;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: DEPTH=16, FWFT=0, AF=14, AE=2
    logic       wr_a = 1'b0, rd_a = 1'b0, clr_a = 1'b0;
    logic [7:0] din_a = 8'h00;
    logic [7:0] dout_a;
    logic       valid_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
    logic [4:0] count_a;

    // Instance B: DEPTH=5, FWFT=1, AF=4, AE=1
    logic       wr_b = 1'b0, rd_b = 1'b0, clr_b = 1'b0;
    logic [7:0] din_b = 8'h00;
    logic [7:0] dout_b;
    logic       valid_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
    logic [2:0] count_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] m_dout_a;
    logic       m_valid_a;
    logic       m_ov_a, m_un_a, m_ov_b, m_un_b;
    int         b_written;

    sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .din(din_a), .rd_en(rd_a), .dout(dout_a),
        .valid(valid_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
        .almost_empty(ae_a), .count(count_a), .overflow(ov_a), .underflow(un_a),
        .clr_err(clr_a)
    );

    sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .din(din_b), .rd_en(rd_b), .dout(dout_b),
        .valid(valid_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
        .almost_empty(ae_b), .count(count_b), .overflow(ov_b), .underflow(un_b),
        .clr_err(clr_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        m_dout_a  = 8'h00;
        m_valid_a = 1'b0;
        m_ov_a = 1'b0; m_un_a = 1'b0;
        m_ov_b = 1'b0; m_un_b = 1'b0;
    endtask

    // One clock of FIFO semantics, expressed on the queues
    task automatic model_step();
        bit rd_ok, wr_ok, was_empty;
        // instance A
        was_empty = (q_a.size() == 0);
        rd_ok = rd_a && !was_empty;
        wr_ok = wr_a && ((q_a.size() < 16) || rd_ok);
        m_valid_a = rd_ok;
        if (rd_ok) m_dout_a = q_a.pop_front();
        if (wr_ok) q_a.push_back(din_a);
        m_ov_a = (wr_a && !wr_ok) ? 1'b1 : (clr_a ? 1'b0 : m_ov_a);
        m_un_a = (rd_a && was_empty) ? 1'b1 : (clr_a ? 1'b0 : m_un_a);
        // instance B
        was_empty = (q_b.size() == 0);
        rd_ok = rd_b && !was_empty;
        wr_ok = wr_b && ((q_b.size() < 5) || rd_ok);
        if (rd_ok) void'(q_b.pop_front());
        if (wr_ok) begin
            q_b.push_back(din_b);
            b_written++;
        end
        m_ov_b = (wr_b && !wr_ok) ? 1'b1 : (clr_b ? 1'b0 : m_ov_b);
        m_un_b = (rd_b && was_empty) ? 1'b1 : (clr_b ? 1'b0 : m_un_b);
    endtask

    task automatic check_all();
        check_val("a_count",  32'(count_a), 32'(q_a.size()));
        check_val("a_empty",  32'(empty_a), 32'(q_a.size() == 0));
        check_val("a_full",   32'(full_a),  32'(q_a.size() == 16));
        check_val("a_afull",  32'(af_a),    32'(q_a.size() >= 14));
        check_val("a_aempty", 32'(ae_a),    32'(q_a.size() <= 2));
        check_val("a_valid",  32'(valid_a), 32'(m_valid_a));
        check_val("a_dout",   32'(dout_a),  32'(m_dout_a));
        check_val("a_ovf",    32'(ov_a),    32'(m_ov_a));
        check_val("a_unf",    32'(un_a),    32'(m_un_a));
        check_val("b_count",  32'(count_b), 32'(q_b.size()));
        check_val("b_empty",  32'(empty_b), 32'(q_b.size() == 0));
        check_val("b_full",   32'(full_b),  32'(q_b.size() == 5));
        check_val("b_afull",  32'(af_b),    32'(q_b.size() >= 4));
        check_val("b_aempty", 32'(ae_b),    32'(q_b.size() <= 1));
        check_val("b_valid",  32'(valid_b), 32'(q_b.size() != 0));
        if (q_b.size() != 0) check_val("b_dout_head", 32'(dout_b), 32'(q_b[0]));
        check_val("b_ovf",    32'(ov_b),    32'(m_ov_b));
        check_val("b_unf",    32'(un_b),    32'(m_un_b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic idle_inputs();
        wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
        wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0;
    endtask

    initial begin
        b_written = 0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Test 1: reset during a burst with count at 5
        for (int i = 0; i < 5; i++) begin
            wr_a = 1'b1; din_a = 8'(8'h30 + i);
            wr_b = 1'b1; din_b = 8'(8'h40 + i);
            tick();
        end
        check_val("t1_pre_count", 32'(count_a), 32'd5);
        rst = 1'b1;
        #3;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        idle_inputs();
        rst = 1'b0;
        tick();

        // Test 2: fill 0x00..0x0F, reject a 17th write, then drain in order
        for (int i = 0; i < 16; i++) begin
            wr_a = 1'b1; din_a = 8'(i);
            tick();
        end
        din_a = 8'hEE;
        tick();
        check_val("t2_overflow", 32'(ov_a), 32'd1);
        wr_a = 1'b0; clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_a = 1'b1;
            tick();
            check_val("t2_drain_dout", 32'(dout_a), 32'(i));
        end
        rd_a = 1'b0;
        tick();
        check_val("t2_empty", 32'(empty_a), 32'd1);

        // Test 4: simultaneous write and read on an empty FIFO, then clear the error
        wr_a = 1'b1; rd_a = 1'b1; din_a = 8'h55;
        tick();
        check_val("t4_count", 32'(count_a), 32'd1);
        check_val("t4_underflow", 32'(un_a), 32'd1);
        wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b1;
        tick();
        check_val("t4_unf_clear", 32'(un_a), 32'd0);
        clr_a = 1'b0; rd_a = 1'b1;
        tick();
        rd_a = 1'b0;

        // Test 3: simultaneous write and read on a full FIFO; 0xAA must come out last
        for (int i = 0; i < 16; i++) begin
            wr_a = 1'b1; din_a = 8'($urandom_range(0, 127));
            tick();
        end
        wr_a = 1'b1; rd_a = 1'b1; din_a = 8'hAA;
        tick();
        check_val("t3_count", 32'(count_a), 32'd16);
        check_val("t3_no_ovf", 32'(ov_a), 32'd0);
        wr_a = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check_val("t3_last_word", 32'(dout_a), 32'h0000_00AA);
        rd_a = 1'b0;
        tick();

        // Test 5 plus random traffic: B streams at least 20 words across wraps, and A runs in parallel
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (b_written >= 20 && cyc >= 300) break;
            wr_a  = 1'($urandom_range(0, 1));
            rd_a  = 1'($urandom_range(0, 1));
            clr_a = ($urandom_range(0, 15) == 0);
            din_a = 8'($urandom);
            wr_b  = 1'($urandom_range(0, 1));
            rd_b  = 1'($urandom_range(0, 1));
            clr_b = ($urandom_range(0, 15) == 0);
            din_b = 8'($urandom);
            tick();
        end
        check_val("t5_stream_done", 32'(b_written >= 20), 32'd1);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
